// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Multi-decade BCD down-counter for the irrigation controller. A preset is
//   loaded (non-BCD digits clamped to 9). Counting is started and paused on
//   command, and the count is decremented once every PRESCALE time-base ticks.
//   At terminal count the timer emits a one-cycle Done pulse. It then either
//   stops at zero, or reloads the preset and keeps running (AUTO_RELOAD).
//
// Parameters
//   DIGITS      number of BCD decades (1..4)
//   PRESCALE    Tick pulses per decrement (1..16)
//   AUTO_RELOAD 1 = reload last loaded value at terminal count, 0 = stop
//
// Ports
//   Clk      in   rising-edge clock
//   Rst      in   asynchronous active-high reset
//   Load     in   load LoadVal into count and reload register
//   LoadVal  in   BCD preset, digit 0 in bits [3:0]
//   Start    in   begin/resume counting
//   Stop     in   pause counting, count held
//   Tick     in   one-cycle time-base strobe
//   Q        out  current BCD count (registered)
//   Running  out  high while in RUN state
//   Zero     out  Q == 0 (combinational)
//   Done     out  one-cycle terminal-count pulse (registered)
module bcd_down_timer #(
  parameter int DIGITS      = 2,
  parameter int PRESCALE    = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Tick,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Running,
  output logic                  Zero,
  output logic                  Done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    reload_reg;
  logic [PW-1:0]   pre_reg;
  logic            done_reg;

  logic [W-1:0]    load_clean;
  logic [W-1:0]    q_dec;
  logic [DIGITS:0] borrow;

  // Clamp every decade of the preset to 9 so Q never holds a non-BCD digit.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
      assign load_clean[4*gi +: 4] =
        (LoadVal[4*gi +: 4] > 4'd9) ? 4'd9 : LoadVal[4*gi +: 4];
    end
  endgenerate

  // Ripple-borrow BCD decrement: a decade at 0 wraps to 9 and passes the
  // borrow upward; decades above the last borrow are untouched.
  assign borrow[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
      logic [3:0] digit;
      assign digit = q_reg[4*gi +: 4];
      assign q_dec[4*gi +: 4] = !borrow[gi]    ? digit :
                                (digit == 4'd0) ? 4'd9  : digit - 4'd1;
      assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
    end
  endgenerate

  logic is_one;
  logic do_reload;
  assign is_one    = (q_reg == W'(1));
  assign do_reload = (AUTO_RELOAD != 0) && (reload_reg != '0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
      pre_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (Load) begin
        q_reg      <= load_clean;
        reload_reg <= load_clean;
        state_reg  <= IDLE;
        pre_reg    <= '0;
      end else if (Stop && state_reg == RUN) begin
        // Pause: count and prescaler phase are held; the Tick is dropped.
        state_reg <= IDLE;
      end else if (Start && state_reg == IDLE && q_reg != '0) begin
        state_reg <= RUN;
        pre_reg   <= '0;
      end else if (Tick && state_reg == RUN) begin
        if (pre_reg == PRE_LAST) begin
          pre_reg <= '0;
          if (is_one) begin
            done_reg <= 1'b1;
            if (do_reload) begin
              q_reg <= reload_reg;
            end else begin
              q_reg     <= '0;
              state_reg <= IDLE;
            end
          end else begin
            q_reg <= q_dec;
          end
        end else begin
          pre_reg <= pre_reg + PW'(1);
        end
      end
    end
  end

  assign Q       = q_reg;
  assign Running = (state_reg == RUN);
  assign Zero    = (q_reg == '0);
  assign Done    = done_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Testbench for bcd_down_timer. Three instances share the stimulus:
//   u0: PRESCALE=1, AUTO_RELOAD=0
//   u1: PRESCALE=1, AUTO_RELOAD=1
//   u2: PRESCALE=4, AUTO_RELOAD=0
// Each directed step pushes the expected outputs of one selected instance
// into a queue. After the clock edge the entry is popped and compared.
module tb_bcd_down_timer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Load = 1'b0, Start = 1'b0, Stop = 1'b0, Tick = 1'b0;
  logic [7:0] LoadVal = 8'h00;

  logic [7:0] q0, q1, q2;
  logic       r0, r1, r2, z0, z1, z2, d0, d1, d2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] q;
    logic       run;
    logic       zero;
    logic       done;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  bcd_down_timer #(.DIGITS(2), .PRESCALE(1), .AUTO_RELOAD(0)) u0 (
    .Clk(Clk), .Rst(Rst), .Load(Load), .LoadVal(LoadVal), .Start(Start),
    .Stop(Stop), .Tick(Tick), .Q(q0), .Running(r0), .Zero(z0), .Done(d0));
  bcd_down_timer #(.DIGITS(2), .PRESCALE(1), .AUTO_RELOAD(1)) u1 (
    .Clk(Clk), .Rst(Rst), .Load(Load), .LoadVal(LoadVal), .Start(Start),
    .Stop(Stop), .Tick(Tick), .Q(q1), .Running(r1), .Zero(z1), .Done(d1));
  bcd_down_timer #(.DIGITS(2), .PRESCALE(4), .AUTO_RELOAD(0)) u2 (
    .Clk(Clk), .Rst(Rst), .Load(Load), .LoadVal(LoadVal), .Start(Start),
    .Stop(Stop), .Tick(Tick), .Q(q2), .Running(r2), .Zero(z2), .Done(d2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_top();
    exp_t e;
    logic [7:0] oq;
    logic       orun, ozero, odone;
    e = sb.pop_front();
    case (e.sel)
      0:       begin oq = q0; orun = r0; ozero = z0; odone = d0; end
      1:       begin oq = q1; orun = r1; ozero = z1; odone = d1; end
      default: begin oq = q2; orun = r2; ozero = z2; odone = d2; end
    endcase
    chk({e.tag, ".Q"}, oq, e.q);
    chk({e.tag, ".Running"}, {7'd0, orun}, {7'd0, e.run});
    chk({e.tag, ".Zero"}, {7'd0, ozero}, {7'd0, e.zero});
    chk({e.tag, ".Done"}, {7'd0, odone}, {7'd0, e.done});
    $display("step %-10s dut=u%0d Q=%h Running=%b Zero=%b Done=%b", e.tag, e.sel,
             oq, orun, ozero, odone);
  endtask

  // Drive one cycle of inputs, record expectations, clock, then compare.
  task automatic step(input string tag, input int sel, input logic ld,
                      input logic [7:0] lv, input logic st, input logic sp,
                      input logic tk, input logic [7:0] eq, input logic er,
                      input logic ed);
    exp_t e;
    e.tag = tag; e.sel = sel; e.q = eq; e.run = er;
    e.zero = (eq == 8'h00); e.done = ed;
    sb.push_back(e);
    Load = ld; LoadVal = lv; Start = st; Stop = sp; Tick = tk;
    @(posedge Clk);
    #1;
    Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
    compare_top();
  endtask

  initial begin
    exp_t e;
    // Power-on reset state
    #2;
    e.tag = "reset"; e.sel = 0; e.q = 8'h00; e.run = 1'b0; e.zero = 1'b1; e.done = 1'b0;
    sb.push_back(e);
    compare_top();
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Borrow across decades, PRESCALE=1
    step("brw_ld",  0, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0);
    step("brw_st",  0, 0, 8'h00, 1, 0, 0, 8'h10, 1, 0);
    step("brw_t1",  0, 0, 8'h00, 0, 0, 1, 8'h09, 1, 0);
    step("brw_t2",  0, 0, 8'h00, 0, 0, 1, 8'h08, 1, 0);
    step("brw_t3",  0, 0, 8'h00, 0, 0, 1, 8'h07, 1, 0);

    // Terminal count, no reload
    step("term_ld", 0, 1, 8'h02, 0, 0, 0, 8'h02, 0, 0);
    step("term_st", 0, 0, 8'h00, 1, 0, 0, 8'h02, 1, 0);
    step("term_t1", 0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
    step("term_t2", 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
    step("term_id", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    step("term_t3", 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);

    // Auto-reload
    step("ar_ld",   1, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0);
    step("ar_st",   1, 0, 8'h00, 1, 0, 0, 8'h03, 1, 0);
    step("ar_t1",   1, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
    step("ar_t2",   1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
    step("ar_t3",   1, 0, 8'h00, 0, 0, 1, 8'h03, 1, 1);
    step("ar_t4",   1, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
    step("ar_t5",   1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
    step("ar_t6",   1, 0, 8'h00, 0, 0, 1, 8'h03, 1, 1);

    // Reload value 1 with Tick held: Done stays high on consecutive cycles
    step("ar1_ld",  1, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0);
    step("ar1_st",  1, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0);
    step("ar1_t1",  1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 1);
    step("ar1_t2",  1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 1);
    step("ar1_id",  1, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0);

    // PRESCALE=4 with a pause: Tick 3 dropped, prescaler cleared on resume
    step("ps_ld",   2, 1, 8'h05, 0, 0, 0, 8'h05, 0, 0);
    step("ps_st",   2, 0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
    step("ps_t1",   2, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0);
    step("ps_t2",   2, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0);
    step("ps_t3sp", 2, 0, 8'h00, 0, 1, 1, 8'h05, 0, 0);
    step("ps_gap",  2, 0, 8'h00, 0, 0, 0, 8'h05, 0, 0);
    step("ps_rs",   2, 0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
    step("ps_t4",   2, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0);
    step("ps_t5",   2, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0);
    step("ps_t6",   2, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0);
    step("ps_t7",   2, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    step("ps_t8",   2, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    step("ps_t9",   2, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    step("ps_t10",  2, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    step("ps_t11",  2, 0, 8'h00, 0, 0, 1, 8'h03, 1, 0);

    // Sanitizing, Start from zero, Tick alongside Start, Load beats terminal step
    step("san_ld",  0, 1, 8'hAF, 0, 0, 0, 8'h99, 0, 0);
    step("san_ld2", 0, 1, 8'h7C, 0, 0, 0, 8'h79, 0, 0);
    step("z_ld",    0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    step("z_st",    0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    step("tks_ld",  0, 1, 8'h05, 0, 0, 0, 8'h05, 0, 0);
    step("tks_st",  0, 0, 8'h00, 1, 0, 1, 8'h05, 1, 0);
    step("tks_t",   0, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    step("lw_ld",   0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0);
    step("lw_st",   0, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0);
    step("lw_tld",  0, 1, 8'h07, 0, 0, 1, 8'h07, 0, 0);

    // Asynchronous reset mid-RUN, observed before any clock edge
    step("ar_pre1", 0, 1, 8'h38, 0, 0, 0, 8'h38, 0, 0);
    step("ar_pre2", 0, 0, 8'h00, 1, 0, 0, 8'h38, 1, 0);
    step("ar_pre3", 0, 0, 8'h00, 0, 0, 1, 8'h37, 1, 0);
    #2;
    Rst = 1'b1;
    #1;
    e.tag = "async_rst"; e.sel = 0; e.q = 8'h00; e.run = 1'b0; e.zero = 1'b1; e.done = 1'b0;
    sb.push_back(e);
    compare_top();
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
